// File: rtl/textcon_pkg.sv
// Shared types and constants for the text console controller.
package textcon_pkg;

   typedef enum logic [1:0] {StIdle, StPut, StClrLine, StClrAll} state_e;

   localparam logic [7:0] CHAR_BS = 8'h08;
   localparam logic [7:0] CHAR_LF = 8'h0A;
   localparam logic [7:0] CHAR_FF = 8'h0C;
   localparam logic [7:0] CHAR_CR = 8'h0D;

   localparam int unsigned DI_CMD_LSB = 24;
   localparam int unsigned DI_X_LSB   = 16;
   localparam int unsigned DI_Y_LSB   = 8;

   // cmd field stays zero; only x, y and the 7-bit character are populated.
   function automatic logic [31:0] pack_cell(input logic [4:0] x, input logic [4:0] y,
                                             input logic [6:0] c);
      logic [31:0] di;
      di = '0;
      di[DI_X_LSB +: 5] = x;
      di[DI_Y_LSB +: 5] = y;
      di[6:0]           = c;
      return di;
   endfunction

endpackage

// File: rtl/textcon_cellgen.sv
// Cell address sequencer for line and screen clears; x/y track the cell currently being written.
module textcon_cellgen
   import textcon_pkg::*;
#(
   parameter int unsigned COLS = 32,
   parameter int unsigned ROWS = 28,
   parameter int unsigned CW   = 10
) (
   input  logic       wclk,
   input  logic       resetn,
   input  logic       start,
   input  logic       all,
   input  logic [4:0] row,
   input  logic       step,
   output logic [4:0] y,
   output logic [4:0] nx,
   output logic [4:0] ny,
   output logic       last
);

   logic [4:0]    x_q, y_q;
   logic [CW-1:0] cnt_q;
   logic          all_q;

   always_comb begin
      nx   = (x_q == 5'(COLS - 1)) ? 5'd0 : x_q + 5'd1;
      ny   = (x_q == 5'(COLS - 1)) ? y_q + 5'd1 : y_q;
      last = (cnt_q == (all_q ? CW'(COLS * ROWS - 1) : CW'(COLS - 1)));
      y    = y_q;
   end

   always_ff @(posedge wclk or negedge resetn) begin
      if (!resetn) begin
         x_q   <= '0;
         y_q   <= '0;
         cnt_q <= '0;
         all_q <= 1'b0;
      end else if (start) begin
         x_q   <= '0;
         y_q   <= row;
         cnt_q <= '0;
         all_q <= all;
      end else if (step) begin
         x_q   <= nx;
         y_q   <= ny;
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/text_console_ctrl.sv
// Byte-stream text console: places printable characters, handles LF/CR/BS/FF, clears lines/screen.
module text_console_ctrl
   import textcon_pkg::*;
#(
   parameter int unsigned COLS  = 32,
   parameter int unsigned ROWS  = 28,
   parameter logic [7:0]  BLANK = 8'h20
) (
   input  logic        wclk,
   input  logic        resetn,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic [3:0]  char_we,
   output logic [31:0] char_di,
   output logic [4:0]  cur_x,
   output logic [4:0]  cur_y,
   output logic        busy
);

   localparam int unsigned CW = $clog2(COLS * ROWS);

   state_e     state_q;
   logic       bs_q;
   logic       printable;
   logic [4:0] next_row;
   logic       gen_start, gen_all, gen_step, gen_last;
   logic [4:0] gen_row, gen_y, gen_nx, gen_ny;

   assign in_ready  = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
   assign next_row  = (cur_y == 5'(ROWS - 1)) ? 5'd0 : cur_y + 5'd1;

   always_comb begin
      gen_start = 1'b0;
      gen_all   = 1'b0;
      gen_row   = next_row;
      if (state_q == StIdle && in_valid) begin
         if (in_data == CHAR_LF) begin
            gen_start = 1'b1;
         end else if (in_data == CHAR_FF) begin
            gen_start = 1'b1;
            gen_all   = 1'b1;
            gen_row   = 5'd0;
         end
      end else if (state_q == StPut && !bs_q && cur_x == 5'(COLS - 1)) begin
         gen_start = 1'b1;
      end
      gen_step = (state_q == StClrLine || state_q == StClrAll) && !gen_last;
   end

   textcon_cellgen #(
      .COLS (COLS),
      .ROWS (ROWS),
      .CW   (CW)
   ) u_cellgen (
      .wclk   (wclk),
      .resetn (resetn),
      .start  (gen_start),
      .all    (gen_all),
      .row    (gen_row),
      .step   (gen_step),
      .y      (gen_y),
      .nx     (gen_nx),
      .ny     (gen_ny),
      .last   (gen_last)
   );

   // Outputs are registered: the write for a cell is visible in the cycle after it is decided.
   always_ff @(posedge wclk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         bs_q    <= 1'b0;
         cur_x   <= '0;
         cur_y   <= '0;
         char_we <= 4'b0000;
         char_di <= '0;
      end else begin
         char_we <= 4'b0000;
         char_di <= '0;
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  if (printable) begin
                     state_q <= StPut;
                     bs_q    <= 1'b0;
                     char_we <= 4'b0001;
                     char_di <= pack_cell(cur_x, cur_y, in_data[6:0]);
                  end else if (in_data == CHAR_LF) begin
                     state_q <= StClrLine;
                     char_we <= 4'b0001;
                     char_di <= pack_cell(5'd0, next_row, BLANK[6:0]);
                  end else if (in_data == CHAR_CR) begin
                     cur_x <= '0;
                  end else if (in_data == CHAR_BS && cur_x != 5'd0) begin
                     state_q <= StPut;
                     bs_q    <= 1'b1;
                     cur_x   <= cur_x - 5'd1;
                     char_we <= 4'b0001;
                     char_di <= pack_cell(cur_x - 5'd1, cur_y, BLANK[6:0]);
                  end else if (in_data == CHAR_FF) begin
                     state_q <= StClrAll;
                     char_we <= 4'b0001;
                     char_di <= pack_cell(5'd0, 5'd0, BLANK[6:0]);
                  end
               end
            end
            StPut: begin
               if (bs_q) begin
                  state_q <= StIdle;
               end else if (cur_x != 5'(COLS - 1)) begin
                  cur_x   <= cur_x + 5'd1;
                  state_q <= StIdle;
               end else begin
                  state_q <= StClrLine;
                  char_we <= 4'b0001;
                  char_di <= pack_cell(5'd0, next_row, BLANK[6:0]);
               end
            end
            StClrLine, StClrAll: begin
               if (gen_last) begin
                  state_q <= StIdle;
                  cur_x   <= '0;
                  cur_y   <= (state_q == StClrLine) ? gen_y : 5'd0;
               end else begin
                  char_we <= 4'b0001;
                  char_di <= pack_cell(gen_nx, gen_ny, BLANK[6:0]);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed self-checking bench for text_console_ctrl.
module tb_text_console_ctrl;

   logic        wclk = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic [3:0]  char_we;
   logic [31:0] char_di;
   logic [4:0]  cur_x, cur_y;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   int          nw = 0;
   logic [31:0] wlog [4096];

   always #5 wclk = ~wclk;

   text_console_ctrl dut (
      .wclk     (wclk),
      .resetn   (resetn),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .char_we  (char_we),
      .char_di  (char_di),
      .cur_x    (cur_x),
      .cur_y    (cur_y),
      .busy     (busy)
   );

   always @(negedge wclk) begin
      if (char_we != 4'b0000) begin
         if (nw < 4096) wlog[nw] <= char_di;
         nw <= nw + 1;
      end
   end

   function automatic logic [31:0] exp_di(input int x, input int y, input logic [7:0] c);
      return (32'(x) << 16) | (32'(y) << 8) | {25'd0, c[6:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      resetn   = 1'b0;
      repeat (2) @(negedge wclk);
      resetn = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge wclk);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge wclk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output int n);
      n = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge wclk);
         if (in_ready) break;
         n++;
      end
      if (!in_ready) check("idle_timeout", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic send_wait(input logic [7:0] b);
      int n;
      send(b);
      wait_idle(2000, n);
   endtask

   initial begin
      int n, base, bad;
      logic [31:0] d;

      do_reset();
      @(negedge wclk);
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_we", {28'd0, char_we}, 32'd0);
      check("rst_di", char_di, 32'd0);
      check("rst_cur", {cur_x, cur_y}, 32'd0);

      // 'A' at home
      send(8'h41);
      @(negedge wclk);
      check("a_we", {28'd0, char_we}, 32'd1);
      check("a_di", char_di, 32'h0000_0041);
      wait_idle(10, n);
      check("a_cur", {cur_x, cur_y}, {22'd0, 5'd1, 5'd0});

      // wrap at end of line from (31,5)
      do_reset();
      for (int i = 0; i < 5; i++) send_wait(8'h0A);
      for (int i = 0; i < 31; i++) send_wait(8'h61);
      check("pos_31_5", {cur_x, cur_y}, {22'd0, 5'd31, 5'd5});
      base = nw;
      send(8'h5A);
      wait_idle(200, n);
      check("z_busy_cycles", n, 33);
      check("z_nwrites", nw - base, 33);
      check("z_first", wlog[base], exp_di(31, 5, 8'h5A));
      bad = 0;
      for (int k = 0; k < 32; k++) if (wlog[base + 1 + k] !== exp_di(k, 6, 8'h20)) bad++;
      check("z_clr_row6", bad, 0);
      check("z_cur", {cur_x, cur_y}, {22'd0, 5'd0, 5'd6});

      // LF from the last row wraps to row 0
      do_reset();
      for (int i = 0; i < 27; i++) send_wait(8'h0A);
      for (int i = 0; i < 7; i++) send_wait(8'h62);
      check("pos_7_27", {cur_x, cur_y}, {22'd0, 5'd7, 5'd27});
      base = nw;
      send(8'h0A);
      @(negedge wclk);
      check("lf_latency", {28'd0, char_we}, 32'd1);
      wait_idle(200, n);
      check("lf_nwrites", nw - base, 32);
      bad = 0;
      for (int k = 0; k < 32; k++) if (wlog[base + k] !== exp_di(k, 0, 8'h20)) bad++;
      check("lf_clr_row0", bad, 0);
      check("lf_cur", {cur_x, cur_y}, 32'd0);

      // form feed clears the whole screen in row-major order
      send_wait(8'h63);
      check("pre_ff_cur", {cur_x, cur_y}, {22'd0, 5'd1, 5'd0});
      base = nw;
      send(8'h0C);
      wait_idle(1200, n);
      check("ff_busy_cycles", n, 896);
      check("ff_nwrites", nw - base, 896);
      bad = 0;
      for (int k = 0; k < 896; k++) if (wlog[base + k] !== exp_di(k % 32, k / 32, 8'h20)) bad++;
      check("ff_order", bad, 0);
      check("ff_last", wlog[base + 895], exp_di(31, 27, 8'h20));
      check("ff_cur", {cur_x, cur_y}, 32'd0);

      // backspace, CR and discarded codes
      do_reset();
      for (int i = 0; i < 3; i++) send_wait(8'h0A);
      base = nw;
      send_wait(8'h08);
      check("bs0_nwrites", nw - base, 0);
      check("bs0_cur", {cur_x, cur_y}, {22'd0, 5'd0, 5'd3});
      for (int i = 0; i < 4; i++) send_wait(8'h64);
      base = nw;
      send_wait(8'h08);
      check("bs4_nwrites", nw - base, 1);
      check("bs4_di", wlog[base], exp_di(3, 3, 8'h20));
      check("bs4_cur", {cur_x, cur_y}, {22'd0, 5'd3, 5'd3});
      base = nw;
      send(8'h07);
      @(negedge wclk);
      check("bel_ready", {31'd0, in_ready}, 32'd1);
      send_wait(8'h80);
      send_wait(8'hFF);
      check("junk_nwrites", nw - base, 0);
      check("junk_cur", {cur_x, cur_y}, {22'd0, 5'd3, 5'd3});
      send_wait(8'h0D);
      check("cr_cur", {cur_x, cur_y}, {22'd0, 5'd0, 5'd3});
      check("cr_nwrites", nw - base, 0);

      // reset asserted in the 100th cycle of a screen clear
      send(8'h0C);
      repeat (99) @(posedge wclk);
      #2 resetn = 1'b0;
      #1;
      check("abort_we", {28'd0, char_we}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      base = nw;
      repeat (2) @(negedge wclk);
      resetn = 1'b1;
      repeat (40) @(negedge wclk);
      check("abort_nwrites", nw - base, 0);
      check("abort_cur", {cur_x, cur_y}, 32'd0);
      check("abort_ready", {31'd0, in_ready}, 32'd1);

      // a fresh character still lands at home after the aborted clear
      send(8'h42);
      @(negedge wclk);
      d = char_di;
      check("post_abort_di", d, exp_di(0, 0, 8'h42));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/text_console_ctrl.md
TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

Interface
REQ-001 Parameter COLS, default 32: text columns; cursor X is 0..COLS-1.
REQ-002 Parameter ROWS, default 28: text rows; cursor Y is 0..ROWS-1.
REQ-003 Parameter BLANK, default 8'h20: character written when erasing cells.
REQ-004 Port wclk, input, 1: main logic clock; the only clock in the block.
REQ-005 Port resetn, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port in_valid, input, 1: byte-stream request from CPU or loader.
REQ-007 Port in_data, input, 8: stream byte, either a character or a control code.
REQ-008 Port in_ready, output, 1: byte accepted on the cycle in_valid and in_ready are both high.
REQ-009 Port char_we, output, 4: char-buffer write strobe; 4'b0001 when writing, else 4'b0000.
REQ-010 Port char_di, output, 32: fields are [31:24] cmd=0, [20:16] x, [12:8] y, [6:0] char; all other bits are 0.
REQ-011 Port cur_x, output, 5: current cursor column.
REQ-012 Port cur_y, output, 5: current cursor row.
REQ-013 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 The controller SHALL be a state machine with states IDLE, PUT, CLRLINE and CLRALL.
REQ-015 in_ready SHALL equal (state==IDLE); in IDLE, char_we SHALL be 0.
REQ-016 Printable byte (0x20..0x7E) accepted: next cycle PUT, writing the byte at (cur_x, cur_y).
REQ-017 After PUT with cur_x<COLS-1: cur_x+1, return to IDLE.
REQ-018 After PUT with cur_x==COLS-1: cur_x=0, perform a line advance (REQ-019).
REQ-019 Line advance SHALL set cur_y=(cur_y+1) mod ROWS (ROWS-1 wraps to 0), then enter CLRLINE.
REQ-020 CLRLINE SHALL write BLANK to columns 0..COLS-1 of the new cur_y, one per cycle, ascending, then return to IDLE (COLS cycles).
REQ-021 0x0A (LF) accepted: cur_x=0 and line advance; no character write.
REQ-022 0x0D (CR) accepted: cur_x=0, stay in IDLE, no write.
REQ-023 0x08 (BS) with cur_x>0: cur_x-1, then one PUT of BLANK at the new position; cursor unchanged after that write.
REQ-024 0x08 (BS) with cur_x==0: no effect.
REQ-025 0x0C (FF) accepted: enter CLRALL, writing BLANK to all COLS*ROWS cells in row-major order (y outer, x inner), one per cycle; then cur_x=cur_y=0, IDLE.
REQ-026 All other bytes (0x00..0x1F except those above, and 0x7F..0xFF) SHALL be accepted and discarded with no state change.
REQ-027 Latency: a byte accepted in cycle N SHALL produce its first char_we in cycle N+1.
REQ-028 cur_x and cur_y SHALL be stable during CLRLINE and CLRALL and update on the cycle the sequence completes.
REQ-029 Clear counters SHALL be sized for COLS*ROWS; 896 cells at default parameters, so 10 bits.

Reset
REQ-030 Asserting resetn (low) SHALL immediately set state=IDLE, cur_x=0, cur_y=0, char_we=0, char_di=0 and clear counters=0; in_ready is then 1 and busy 0.
REQ-031 Reset mid-CLRLINE or mid-CLRALL SHALL abort the sequence; cells already written remain, and no auto-clear runs after release.

Structure
REQ-032 Shared package textcon_pkg SHALL hold the state enum, the control-code constants (LF, CR, BS, FF) and the char_di field positions.
REQ-033 One sub-module, textcon_cellgen, SHALL be used: a cell address sequencer (x/y counters with a done flag) shared by CLRLINE and CLRALL.

Verification
REQ-034 After reset, send 'A' (0x41): the next cycle shows char_we=1, char_di=32'h0000_0041 with x=0, y=0; then cur_x=1.
REQ-035 With the cursor at (31,5), send 'Z': write at x=31, y=5, then 32 BLANK writes on row 6; afterwards cur=(0,6) and in_ready is low for 33 cycles.
REQ-036 With the cursor at (7,27), send LF: 32 BLANK writes on row 0; afterwards cur=(0,0).
REQ-037 Send FF: exactly 896 writes covering every (x,y) once; final write at (31,27); cur=(0,0).
REQ-038 BS at (0,3) gives no write; BS at (4,3) gives a BLANK write at (3,3) and cur=(3,3); 0x07 and 0x80 are accepted with no write.
REQ-039 Assert resetn at the 100th cycle of CLRALL: char_we drops immediately; after release, cur=(0,0), in_ready=1, and no further writes occur.
